// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse position tracker.
// This package holds the status-byte bit positions, the speed encodings and the fixed-point widths.
package mouse_pkg;

    localparam int ALWAYS1 = 3;
    localparam int XSIGN   = 4;
    localparam int YSIGN   = 5;
    localparam int XOVF    = 6;
    localparam int YOVF    = 7;

    localparam int FRAC_W  = 2;
    // Sized so an inverted -256 at x2 gain (+2048 quarter pixels) still fits as a positive value.
    localparam int STEP_W  = 13;

    typedef enum logic [1:0] {
        SPEED_QUARTER = 2'd0,
        SPEED_HALF    = 2'd1,
        SPEED_ONE     = 2'd2,
        SPEED_DOUBLE  = 2'd3
    } speed_e;

endpackage

// File: rtl/mouse_axis_update.sv
// One cursor axis: delta decode/saturate/scale in S1, then fixed-point add and clamp/wrap in S2.
// Position is held as {pixel, frac} so that low-gain movement accumulates across packets.
module mouse_axis_update
    import mouse_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int LIMIT   = 640,
    parameter bit INVERT  = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_s1_en,
    input  logic               i_s2_en,
    input  logic               i_sign,
    input  logic               i_ovf,
    input  logic [7:0]         i_delta,
    input  logic [1:0]         i_speed,
    input  logic               i_wrap_en,
    input  logic               i_load_en,
    input  logic [COORD_W-1:0] i_load_val,
    output logic [COORD_W-1:0] o_pos
);

    localparam int SW = COORD_W + FRAC_W + STEP_W;
    localparam logic signed [SW-1:0] LIM = SW'(LIMIT);
    localparam logic [COORD_W-1:0] RESET_POS = COORD_W'(LIMIT / 2);

    logic signed [9:0]               w_raw;
    logic signed [STEP_W-1:0]        w_step;
    logic signed [SW-1:0]            w_sum;
    logic [COORD_W+FRAC_W-1:0]       w_next;
    logic signed [STEP_W-1:0]        r_step;
    logic [COORD_W-1:0]              r_pos;
    logic [FRAC_W-1:0]               r_frac;

    // A single wrap correction is applied; anything still out of range falls back to the clamp.
    function automatic logic [COORD_W+FRAC_W-1:0] fitRange(
        input logic signed [SW-1:0] sum,
        input logic                 wrap
    );
        logic signed [SW-1:0] pix;
        logic [FRAC_W-1:0]    frac;
        pix  = sum >>> FRAC_W;
        frac = sum[FRAC_W-1:0];
        if (wrap) begin
            if (pix < 0)
                pix = pix + LIM;
            else if (pix >= LIM)
                pix = pix - LIM;
        end
        if (pix < 0)
            return '0;
        if (pix >= LIM)
            return {COORD_W'(LIMIT - 1), {FRAC_W{1'b0}}};
        return {pix[COORD_W-1:0], frac};
    endfunction

    always_comb begin
        if (i_ovf)
            w_raw = i_sign ? -10'sd256 : 10'sd255;
        else
            w_raw = {i_sign, i_sign, i_delta};
        if (INVERT)
            w_raw = -w_raw;
        w_step = STEP_W'(w_raw) <<< i_speed;
    end

    always_comb begin
        w_sum  = $signed({{(SW-COORD_W-FRAC_W){1'b0}}, r_pos, r_frac}) + SW'(r_step);
        w_next = fitRange(w_sum, i_wrap_en);
    end

    // A load landing in the same cycle as an S2 update overrides the delta.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step <= '0;
            r_pos  <= RESET_POS;
            r_frac <= '0;
        end else begin
            if (i_s1_en)
                r_step <= w_step;
            if (i_load_en) begin
                r_pos  <= i_load_val;
                r_frac <= '0;
            end else if (i_s2_en) begin
                {r_pos, r_frac} <= w_next;
            end
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/mouse_position_tracker.sv
// Absolute cursor tracker fed by decoded 3-byte PS/2 packets: two-stage position pipeline per axis,
// button press/release events, preload, and a saturating count of malformed packets.
module mouse_position_tracker
    import mouse_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int LIMIT_X  = 640,
    parameter int LIMIT_Y  = 480,
    parameter bit INVERT_Y = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pkt_valid,
    input  logic [7:0]         i_pkt_status,
    input  logic [7:0]         i_pkt_dx,
    input  logic [7:0]         i_pkt_dy,
    input  logic [1:0]         i_speed,
    input  logic               i_wrap_en,
    input  logic               i_load_en,
    input  logic [COORD_W-1:0] i_load_x,
    input  logic [COORD_W-1:0] i_load_y,
    output logic [COORD_W-1:0] o_mouse_x,
    output logic [COORD_W-1:0] o_mouse_y,
    output logic [2:0]         o_mouse_btn,
    output logic [2:0]         o_btn_press,
    output logic [2:0]         o_btn_release,
    output logic               o_pos_valid,
    output logic [7:0]         o_drop_cnt
);

    logic       w_pkt_ok;
    logic       w_pkt_bad;
    logic       r_s1_valid;
    logic [2:0] r_s1_btn;
    logic [7:0] r_drop_cnt;
    logic [2:0] r_btn;
    logic [2:0] r_press;
    logic [2:0] r_release;
    logic       r_pos_valid;

    assign w_pkt_ok  = i_pkt_valid &  i_pkt_status[ALWAYS1];
    assign w_pkt_bad = i_pkt_valid & ~i_pkt_status[ALWAYS1];

    mouse_axis_update #(
        .COORD_W (COORD_W),
        .LIMIT   (LIMIT_X),
        .INVERT  (1'b0)
    ) u_axis_x (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_s1_en    (w_pkt_ok),
        .i_s2_en    (r_s1_valid),
        .i_sign     (i_pkt_status[XSIGN]),
        .i_ovf      (i_pkt_status[XOVF]),
        .i_delta    (i_pkt_dx),
        .i_speed    (i_speed),
        .i_wrap_en  (i_wrap_en),
        .i_load_en  (i_load_en),
        .i_load_val (i_load_x),
        .o_pos      (o_mouse_x)
    );

    mouse_axis_update #(
        .COORD_W (COORD_W),
        .LIMIT   (LIMIT_Y),
        .INVERT  (INVERT_Y)
    ) u_axis_y (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_s1_en    (w_pkt_ok),
        .i_s2_en    (r_s1_valid),
        .i_sign     (i_pkt_status[YSIGN]),
        .i_ovf      (i_pkt_status[YOVF]),
        .i_delta    (i_pkt_dy),
        .i_speed    (i_speed),
        .i_wrap_en  (i_wrap_en),
        .i_load_en  (i_load_en),
        .i_load_val (i_load_y),
        .o_pos      (o_mouse_y)
    );

    // Malformed packets never enter the pipeline, they only bump the drop counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_btn   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_s1_valid <= w_pkt_ok;
            if (w_pkt_ok)
                r_s1_btn <= i_pkt_status[2:0];
            if (w_pkt_bad && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Buttons always register with a packet; a coincident load only suppresses the edge events.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn       <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_pos_valid <= 1'b0;
        end else begin
            r_pos_valid <= r_s1_valid | i_load_en;
            r_press     <= '0;
            r_release   <= '0;
            if (r_s1_valid) begin
                r_btn <= r_s1_btn;
                if (!i_load_en) begin
                    r_press   <=  r_s1_btn & ~r_btn;
                    r_release <= ~r_s1_btn &  r_btn;
                end
            end
        end
    end

    assign o_mouse_btn   = r_btn;
    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;
    assign o_pos_valid   = r_pos_valid;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Self-checking bench for mouse_position_tracker: a vector table, hand-written corner sequences,
// and random packets compared against an integer quarter-pixel model of the cursor.
module tb_mouse_position_tracker;

    localparam int COORD_W = 10;
    localparam int LIMIT_X = 640;
    localparam int LIMIT_Y = 480;

    logic               clk = 1'b0;
    logic               rstN;
    logic               pktValid;
    logic [7:0]         pktStatus;
    logic [7:0]         pktDx;
    logic [7:0]         pktDy;
    logic [1:0]         speed;
    logic               wrapEn;
    logic               loadEn;
    logic [COORD_W-1:0] loadX;
    logic [COORD_W-1:0] loadY;
    logic [COORD_W-1:0] mouseX;
    logic [COORD_W-1:0] mouseY;
    logic [2:0]         mouseBtn;
    logic [2:0]         btnPress;
    logic [2:0]         btnRelease;
    logic               posValid;
    logic [7:0]         dropCnt;

    int checks = 0;
    int errors = 0;

    // Model state: positions in quarter pixels
    int         mxq, myq, mdrop;
    logic [2:0] mbtn, mpress, mrelease;
    logic       mvalid;

    typedef struct {
        logic [7:0] status;
        logic [7:0] dx;
        logic [7:0] dy;
        logic [1:0] speed;
        logic       wrap;
        int         expX;
        int         expY;
        logic       expValid;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    mouse_position_tracker #(
        .COORD_W  (COORD_W),
        .LIMIT_X  (LIMIT_X),
        .LIMIT_Y  (LIMIT_Y),
        .INVERT_Y (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_pkt_valid   (pktValid),
        .i_pkt_status  (pktStatus),
        .i_pkt_dx      (pktDx),
        .i_pkt_dy      (pktDy),
        .i_speed       (speed),
        .i_wrap_en     (wrapEn),
        .i_load_en     (loadEn),
        .i_load_x      (loadX),
        .i_load_y      (loadY),
        .o_mouse_x     (mouseX),
        .o_mouse_y     (mouseY),
        .o_mouse_btn   (mouseBtn),
        .o_btn_press   (btnPress),
        .o_btn_release (btnRelease),
        .o_pos_valid   (posValid),
        .o_drop_cnt    (dropCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    function automatic int decodeRaw(input logic sign, input logic ovf, input logic [7:0] b);
        if (ovf)
            return sign ? -256 : 255;
        return sign ? int'(b) - 256 : int'(b);
    endfunction

    function automatic int floorDiv4(input int v);
        return (v >= 0) ? v / 4 : -((-v + 3) / 4);
    endfunction

    // Move one axis by raw counts at the given gain and fold the result back into 0..lim-1.
    function automatic int axisStep(input int q, input int raw, input int spd, input int lim, input logic wrap);
        int n, p, f;
        n = q + raw * (1 << spd);
        p = floorDiv4(n);
        f = n - 4 * p;
        if (wrap) begin
            if (p < 0)
                p = p + lim;
            else if (p >= lim)
                p = p - lim;
        end
        if (p < 0) begin
            p = 0;
            f = 0;
        end else if (p >= lim) begin
            p = lim - 1;
            f = 0;
        end
        return 4 * p + f;
    endfunction

    task automatic modelPacket(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy,
                               input logic [1:0] spd, input logic wrap);
        mpress   = 3'b000;
        mrelease = 3'b000;
        if (!st[3]) begin
            mvalid = 1'b0;
            if (mdrop < 255)
                mdrop++;
            return;
        end
        mvalid   = 1'b1;
        mxq      = axisStep(mxq, decodeRaw(st[4], st[6], dx), int'(spd), LIMIT_X, wrap);
        myq      = axisStep(myq, -decodeRaw(st[5], st[7], dy), int'(spd), LIMIT_Y, wrap);
        mpress   = st[2:0] & ~mbtn;
        mrelease = ~st[2:0] & mbtn;
        mbtn     = st[2:0];
    endtask

    task automatic modelReset();
        mxq = (LIMIT_X / 2) * 4;
        myq = (LIMIT_Y / 2) * 4;
        mdrop = 0;
        mbtn = 3'b000;
        mpress = 3'b000;
        mrelease = 3'b000;
        mvalid = 1'b0;
    endtask

    // Drive one packet and advance to the cycle where its result is visible.
    task automatic applyStimulus(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy,
                                 input logic [1:0] spd, input logic wrap);
        pktStatus = st;
        pktDx     = dx;
        pktDy     = dy;
        speed     = spd;
        wrapEn    = wrap;
        pktValid  = 1'b1;
        modelPacket(st, dx, dy, spd, wrap);
        tick();
        pktValid  = 1'b0;
        tick();
    endtask

    task automatic doLoad(input int x, input int y);
        loadX  = COORD_W'(x);
        loadY  = COORD_W'(y);
        loadEn = 1'b1;
        tick();
        loadEn = 1'b0;
        mxq = x * 4;
        myq = y * 4;
        mpress = 3'b000;
        mrelease = 3'b000;
        mvalid = 1'b1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput($sformatf("%s x", tag), int'(mouseX), mxq / 4);
        checkOutput($sformatf("%s y", tag), int'(mouseY), myq / 4);
        checkOutput($sformatf("%s btn", tag), int'(mouseBtn), int'(mbtn));
        checkOutput($sformatf("%s press", tag), int'(btnPress), int'(mpress));
        checkOutput($sformatf("%s release", tag), int'(btnRelease), int'(mrelease));
        checkOutput($sformatf("%s valid", tag), int'(posValid), int'(mvalid));
        checkOutput($sformatf("%s drop", tag), int'(dropCnt), mdrop);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'h08, 8'h0A, 8'h05, 2'd2, 1'b0, 330, 235, 1'b1};
        vecs[1]  = '{8'h08, 8'h14, 8'h00, 2'd2, 1'b0, 350, 235, 1'b1};
        vecs[2]  = '{8'h18, 8'hEC, 8'h00, 2'd2, 1'b0, 330, 235, 1'b1};
        vecs[3]  = '{8'h28, 8'h00, 8'hFB, 2'd2, 1'b0, 330, 240, 1'b1};
        vecs[4]  = '{8'h08, 8'h01, 8'h00, 2'd3, 1'b0, 332, 240, 1'b1};
        vecs[5]  = '{8'h08, 8'h04, 8'h00, 2'd1, 1'b0, 334, 240, 1'b1};
        vecs[6]  = '{8'h48, 8'h00, 8'h00, 2'd2, 1'b0, 589, 240, 1'b1};
        vecs[7]  = '{8'h58, 8'h00, 8'h00, 2'd2, 1'b0, 333, 240, 1'b1};
        vecs[8]  = '{8'h00, 8'h33, 8'h44, 2'd2, 1'b0, 333, 240, 1'b0};
        vecs[9]  = '{8'hA8, 8'h00, 8'h00, 2'd2, 1'b0, 333, 479, 1'b1};
        vecs[10] = '{8'h88, 8'h00, 8'h00, 2'd2, 1'b0, 333, 224, 1'b1};
        vecs[11] = '{8'h18, 8'h00, 8'h00, 2'd2, 1'b0,  77, 224, 1'b1};
        vecs[12] = '{8'h18, 8'h00, 8'h00, 2'd2, 1'b1, 461, 224, 1'b1};
        vecs[13] = '{8'h08, 8'hFF, 8'h00, 2'd3, 1'b1, 331, 224, 1'b1};
        vecs[14] = '{8'h08, 8'hFF, 8'h00, 2'd3, 1'b0, 639, 224, 1'b1};

        rstN = 1'b0;
        pktValid = 1'b0;
        pktStatus = '0;
        pktDx = '0;
        pktDy = '0;
        speed = 2'd2;
        wrapEn = 1'b0;
        loadEn = 1'b0;
        loadX = '0;
        loadY = '0;
        modelReset();
        repeat (3) tick();
        rstN = 1'b1;
        tick();

        checkOutput("reset x", int'(mouseX), 320);
        checkOutput("reset y", int'(mouseY), 240);
        checkOutput("reset btn", int'(mouseBtn), 0);
        checkOutput("reset press", int'(btnPress), 0);
        checkOutput("reset release", int'(btnRelease), 0);
        checkOutput("reset valid", int'(posValid), 0);
        checkOutput("reset drop", int'(dropCnt), 0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].status, vecs[i].dx, vecs[i].dy, vecs[i].speed, vecs[i].wrap);
            checkOutput($sformatf("vec%0d valid", i), int'(posValid), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d x", i), int'(mouseX), vecs[i].expX);
            checkOutput($sformatf("vec%0d y", i), int'(mouseY), vecs[i].expY);
        end
        checkOutput("table drop", int'(dropCnt), 1);

        // Clamp versus wrap at the right-hand edge
        doLoad(630, 240);
        checkOutput("load valid", int'(posValid), 1);
        checkOutput("load x", int'(mouseX), 630);
        applyStimulus(8'h08, 8'h14, 8'h00, 2'd2, 1'b0);
        checkOutput("clamp x", int'(mouseX), 639);
        doLoad(630, 240);
        applyStimulus(8'h08, 8'h14, 8'h00, 2'd2, 1'b1);
        checkOutput("wrap x", int'(mouseX), 10);

        // Quarter gain: three packets of +1 accumulate in the fraction
        doLoad(320, 240);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h08, 8'h01, 8'h00, 2'd0, 1'b0);
            checkOutput($sformatf("quarter x%0d", i), int'(mouseX), (i == 3) ? 321 : 320);
        end

        // Button events
        applyStimulus(8'h08, 8'h00, 8'h00, 2'd2, 1'b0);
        checkOutput("btn idle press", int'(btnPress), 0);
        applyStimulus(8'h09, 8'h00, 8'h00, 2'd2, 1'b0);
        checkOutput("btn press", int'(btnPress), 1);
        checkOutput("btn state", int'(mouseBtn), 1);
        applyStimulus(8'h08, 8'h00, 8'h00, 2'd2, 1'b0);
        checkOutput("btn release", int'(btnRelease), 1);
        checkOutput("btn no press", int'(btnPress), 0);

        // Load coincident with the S2 update of dx=+5: load wins, buttons still register
        pktStatus = 8'h09;
        pktDx = 8'h05;
        pktDy = 8'h00;
        speed = 2'd2;
        pktValid = 1'b1;
        tick();
        pktValid = 1'b0;
        loadX = 10'd7;
        loadY = 10'd50;
        loadEn = 1'b1;
        tick();
        loadEn = 1'b0;
        checkOutput("coincide x", int'(mouseX), 7);
        checkOutput("coincide y", int'(mouseY), 50);
        checkOutput("coincide valid", int'(posValid), 1);
        checkOutput("coincide btn", int'(mouseBtn), 1);
        checkOutput("coincide press", int'(btnPress), 0);
        mxq = 28;
        myq = 200;
        mbtn = 3'b001;

        // Back-to-back packets on consecutive cycles
        doLoad(100, 100);
        pktStatus = 8'h09;
        pktDx = 8'h03;
        pktDy = 8'h00;
        pktValid = 1'b1;
        tick();
        pktDx = 8'h04;
        tick();
        pktValid = 1'b0;
        checkOutput("b2b first valid", int'(posValid), 1);
        checkOutput("b2b first x", int'(mouseX), 103);
        tick();
        checkOutput("b2b second valid", int'(posValid), 1);
        checkOutput("b2b second x", int'(mouseX), 107);
        tick();
        checkOutput("b2b idle valid", int'(posValid), 0);
        mxq = 107 * 4;
        myq = 100 * 4;
        mpress = 3'b000;
        mrelease = 3'b000;

        // Random packets and occasional loads against the model
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                doLoad(int'($urandom_range(0, LIMIT_X - 1)), int'($urandom_range(0, LIMIT_Y - 1)));
            end else begin
                logic [7:0] st;
                st = 8'($urandom);
                st[3] = ($urandom_range(0, 7) != 0);
                applyStimulus(st, 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
            end
            checkModel($sformatf("rnd%0d", i));
        end

        // Reset while a packet is in flight: no update, no strobe
        pktStatus = 8'h08;
        pktDx = 8'h0A;
        pktValid = 1'b1;
        tick();
        pktValid = 1'b0;
        #2 rstN = 1'b0;
        #1 rstN = 1'b1;
        tick();
        modelReset();
        checkModel("midreset");

        // Drop counter saturation
        pktStatus = 8'h00;
        pktValid = 1'b1;
        repeat (260) tick();
        pktValid = 1'b0;
        tick();
        checkOutput("drop saturate", int'(dropCnt), 255);
        checkOutput("drop no valid", int'(posValid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
